// File: rtl/key_seq_pkg.sv
// -----------------------------------------------------------------------------
// key_seq_pkg
// Shared constants for the push-button command front end.
//   NUM_KEYS  : number of board keys handled
//   CODE_W    : width of a command code (key index 0..4)
//   CNT_W     : width of the per-key debounce counter
//   KEY0..4   : key index constants (KEY4 is the lab reset key, treated like
//               any other key here)
//   next_key  : round-robin successor of a key index, wrapping 4 -> 0
// -----------------------------------------------------------------------------
package key_seq_pkg;

    localparam int NUM_KEYS = 5;
    localparam int CODE_W   = 3;
    localparam int CNT_W    = 8;

    localparam logic [CODE_W-1:0] KEY0 = 3'd0;
    localparam logic [CODE_W-1:0] KEY1 = 3'd1;
    localparam logic [CODE_W-1:0] KEY2 = 3'd2;
    localparam logic [CODE_W-1:0] KEY3 = 3'd3;
    localparam logic [CODE_W-1:0] KEY4 = 3'd4;

    function automatic logic [CODE_W-1:0] next_key(input logic [CODE_W-1:0] k);
        return (k == KEY4) ? KEY0 : k + 3'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One key: two-flop synchroniser, debounce counter with stable level, and a
// rising-edge (press) detector on the stable level.
//   clk     : system clock
//   srst    : synchronous active-high reset
//   btn_n   : raw active-low key, asynchronous to clk
//   deb_en  : 1 = debounce, 0 = stable level follows the synchronised key
//   pressed : debounced pressed level (registered)
//   rise    : one-cycle pulse when the stable level goes 0 -> 1
// -----------------------------------------------------------------------------
module key_debounce
    import key_seq_pkg::*;
#(
    parameter int DEB_CYCLES = 3
) (
    input  logic clk,
    input  logic srst,
    input  logic btn_n,
    input  logic deb_en,
    output logic pressed,
    output logic rise
);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             prev_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            prev_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= ~btn_n;
            sync2_reg <= sync1_reg;
            prev_reg  <= stable_reg;
            if (!deb_en) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                // Level has differed for DEB_CYCLES consecutive cycles.
                stable_reg <= ~stable_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign pressed = stable_reg;
    // Both operands are registers, so the pulse has no input->output path.
    assign rise    = stable_reg & ~prev_reg;

endmodule

// File: rtl/key_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// key_cmd_sequencer
// Turns each debounced key press into exactly one command. Presses are latched
// in a pending mask, arbitrated round-robin and queued in a small
// first-word-fall-through FIFO read through a valid/ready handshake.
//   clk_50m     : system clock
//   rst         : synchronous active-high reset
//   btn_n_i     : raw active-low keys
//   deb_en_i    : 1 = debounce active, 0 = bypass
//   cmd_ready_i : datapath accepts the head command
//   cmd_valid_o : FIFO not empty
//   cmd_code_o  : key index of the head command, 0 when empty
//   pressed_o   : debounced pressed levels
//   fifo_cnt_o  : FIFO occupancy
//   overflow_o  : sticky, a press was merged into an already pending one
// -----------------------------------------------------------------------------
module key_cmd_sequencer
    import key_seq_pkg::*;
#(
    parameter int DEB_CYCLES = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_50m,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] btn_n_i,
    input  logic                deb_en_i,
    input  logic                cmd_ready_i,
    output logic                cmd_valid_o,
    output logic [CODE_W-1:0]   cmd_code_o,
    output logic [NUM_KEYS-1:0] pressed_o,
    output logic [2:0]          fifo_cnt_o,
    output logic                overflow_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    logic [NUM_KEYS-1:0] ev;
    logic [NUM_KEYS-1:0] pend_reg;
    logic [NUM_KEYS-1:0] pend_next;
    logic [CODE_W-1:0]   rr_reg;
    logic                overflow_reg;
    logic                ovf_event;

    logic                grant_any;
    logic [CODE_W-1:0]   grant_idx;
    logic [3:0]          scan_idx;

    logic [CODE_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [FCNT_W-1:0]   cnt_reg;
    logic                can_push;
    logic                push;
    logic                pop;

    // ---------------- per-key front end ----------------
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk     (clk_50m),
                .srst    (rst),
                .btn_n   (btn_n_i[gi]),
                .deb_en  (deb_en_i),
                .pressed (pressed_o[gi]),
                .rise    (ev[gi])
            );
        end
    endgenerate

    // ---------------- FIFO status ----------------
    assign cmd_valid_o = (cnt_reg != '0);
    assign pop         = cmd_valid_o & cmd_ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign can_push    = (cnt_reg < FCNT_W'(FIFO_DEPTH)) | pop;
    assign push        = grant_any & can_push;

    // ---------------- round-robin scan ----------------
    // Walk offsets from high to low so the lowest offset from rr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_reg} + 4'(k);
            if (scan_idx >= 4'(NUM_KEYS)) begin
                scan_idx = scan_idx - 4'(NUM_KEYS);
            end
            if (pend_reg[scan_idx[CODE_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[CODE_W-1:0];
            end
        end
    end

    // ---------------- pending mask ----------------
    // Clear the granted bit first so a new press on the granted key in the
    // same cycle re-sets it without counting as a merge.
    always_comb begin
        pend_next = pend_reg;
        ovf_event = 1'b0;
        if (push) begin
            pend_next[grant_idx] = 1'b0;
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (ev[i]) begin
                if (pend_reg[i] && !(push && (grant_idx == CODE_W'(i)))) begin
                    ovf_event = 1'b1;
                end
                pend_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            pend_reg     <= '0;
            rr_reg       <= KEY0;
            overflow_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
        end else begin
            pend_reg <= pend_next;
            if (ovf_event) begin
                overflow_reg <= 1'b1;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                rr_reg     <= next_key(grant_idx);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + FCNT_W'(1);
                2'b01:   cnt_reg <= cnt_reg - FCNT_W'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_50m) begin
        if (push) begin
            mem[wr_ptr_reg] <= grant_idx;
        end
    end

    assign cmd_code_o = cmd_valid_o ? mem[rd_ptr_reg] : '0;
    assign fifo_cnt_o = 3'(cnt_reg);
    assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_key_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_key_cmd_sequencer
// Directed bench for key_cmd_sequencer: reset, bypass press, debounce glitch
// and press, arbitration order, FIFO full / overflow, reset mid-operation.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_key_cmd_sequencer;
    import key_seq_pkg::*;

    logic                clk_50m;
    logic                rst;
    logic [NUM_KEYS-1:0] btn_n_i;
    logic                deb_en_i;
    logic                cmd_ready_i;
    logic                cmd_valid_o;
    logic [CODE_W-1:0]   cmd_code_o;
    logic [NUM_KEYS-1:0] pressed_o;
    logic [2:0]          fifo_cnt_o;
    logic                overflow_o;

    int checks   = 0;
    int failures = 0;

    key_cmd_sequencer #(
        .DEB_CYCLES (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .btn_n_i     (btn_n_i),
        .deb_en_i    (deb_en_i),
        .cmd_ready_i (cmd_ready_i),
        .cmd_valid_o (cmd_valid_o),
        .cmd_code_o  (cmd_code_o),
        .pressed_o   (pressed_o),
        .fifo_cnt_o  (fifo_cnt_o),
        .overflow_o  (overflow_o)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    // One line per accepted command.
    always @(negedge clk_50m) begin
        if (!rst && cmd_valid_o && cmd_ready_i) begin
            $display("cmd code=%0d fifo_cnt=%0d t=%0t", cmd_code_o, fifo_cnt_o, $time);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_key3();
        btn_n_i = 5'b10111;
        tick(2);
        btn_n_i = 5'b11111;
        tick(2);
    endtask

    int vcnt;
    int seen;
    int n3;
    int bad;

    initial begin
        rst         = 1'b1;
        btn_n_i     = 5'b11111;
        deb_en_i    = 1'b0;
        cmd_ready_i = 1'b0;

        // ---------------- reset ----------------
        tick(2);
        chk("rst_valid",    8'(cmd_valid_o), 8'd0);
        chk("rst_code",     8'(cmd_code_o),  8'd0);
        chk("rst_pressed",  8'(pressed_o),   8'd0);
        chk("rst_cnt",      8'(fifo_cnt_o),  8'd0);
        chk("rst_overflow", 8'(overflow_o),  8'd0);
        rst = 1'b0;
        tick(2);

        // ---------------- bypass press of key 0 ----------------
        deb_en_i    = 1'b0;
        cmd_ready_i = 1'b1;
        btn_n_i     = 5'b11110;          // first sampled at edge k
        tick(2);                         // after k+1
        chk("byp_pressed_k1", 8'(pressed_o[0]), 8'd0);
        tick(1);                         // after k+2
        chk("byp_pressed_k2", 8'(pressed_o[0]), 8'd1);
        tick(1);                         // after k+3
        chk("byp_valid_k3", 8'(cmd_valid_o), 8'd0);
        tick(1);                         // after k+4
        chk("byp_valid_k4", 8'(cmd_valid_o), 8'd1);
        chk("byp_code_k4",  8'(cmd_code_o),  8'd0);
        btn_n_i = 5'b11111;              // five low samples k..k+4
        tick(1);
        chk("byp_valid_k5", 8'(cmd_valid_o), 8'd0);
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (cmd_valid_o) vcnt++;
        end
        chk("byp_extra_cmds", 8'(vcnt), 8'd0);
        chk("byp_released", 8'(pressed_o), 8'd0);

        // ---------------- debounce: glitch then press on key 1 ----------------
        deb_en_i = 1'b1;
        tick(2);
        btn_n_i = 5'b11101;
        tick(2);
        btn_n_i = 5'b11111;
        seen = 0;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (pressed_o[1]) seen++;
            if (cmd_valid_o) vcnt++;
        end
        chk("glitch_pressed", 8'(seen), 8'd0);
        chk("glitch_cmd",     8'(vcnt), 8'd0);

        btn_n_i = 5'b11101;              // edge k
        tick(4);                         // after k+3
        chk("deb_pressed_k3", 8'(pressed_o[1]), 8'd0);
        tick(1);                         // after k+4 = k+1+DEB_CYCLES
        chk("deb_pressed_k4", 8'(pressed_o[1]), 8'd1);
        tick(1);                         // after k+5, six low samples
        btn_n_i = 5'b11111;
        tick(1);                         // after k+6 = k+3+DEB_CYCLES
        chk("deb_valid", 8'(cmd_valid_o), 8'd1);
        chk("deb_code",  8'(cmd_code_o),  8'd1);
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (cmd_valid_o) vcnt++;
        end
        chk("deb_extra_cmds", 8'(vcnt), 8'd0);
        chk("deb_released", 8'(pressed_o[1]), 8'd0);

        // ---------------- arbitration, rr = 0 after reset ----------------
        deb_en_i    = 1'b0;
        cmd_ready_i = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        btn_n_i = 5'b01010;              // keys 0,2,4 at edge k
        tick(5);                         // after k+4
        chk("arb_cnt1",  8'(fifo_cnt_o), 8'd1);
        chk("arb_head0", 8'(cmd_code_o), 8'd0);
        btn_n_i = 5'b11111;
        tick(1);
        chk("arb_cnt2", 8'(fifo_cnt_o), 8'd2);
        tick(1);
        chk("arb_cnt3", 8'(fifo_cnt_o), 8'd3);
        tick(1);
        chk("arb_cnt3_hold", 8'(fifo_cnt_o), 8'd3);
        cmd_ready_i = 1'b1;
        chk("arb_pop_code0", 8'(cmd_code_o), 8'd0);
        tick(1);
        chk("arb_pop_code2", 8'(cmd_code_o), 8'd2);
        chk("arb_pop_valid2", 8'(cmd_valid_o), 8'd1);
        tick(1);
        chk("arb_pop_code4", 8'(cmd_code_o), 8'd4);
        chk("arb_pop_valid4", 8'(cmd_valid_o), 8'd1);
        tick(1);
        chk("arb_empty", 8'(cmd_valid_o), 8'd0);
        tick(4);

        // ---------------- FIFO full and overflow on key 3 ----------------
        cmd_ready_i = 1'b0;
        for (int p = 0; p < 5; p++) press_key3();
        tick(4);
        chk("full_cnt",      8'(fifo_cnt_o), 8'd4);
        chk("full_no_ovf",   8'(overflow_o), 8'd0);
        press_key3();
        tick(4);
        chk("full_ovf",      8'(overflow_o), 8'd1);
        chk("full_cnt_hold", 8'(fifo_cnt_o), 8'd4);
        cmd_ready_i = 1'b1;
        n3  = 0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid_o && cmd_code_o == KEY3) n3++;
            if (cmd_valid_o && cmd_code_o != KEY3) bad++;
            tick(1);
        end
        chk("drain_code3", 8'(n3),  8'd5);
        chk("drain_other", 8'(bad), 8'd0);
        chk("drain_ovf_sticky", 8'(overflow_o), 8'd1);
        chk("drain_cnt", 8'(fifo_cnt_o), 8'd0);

        // ---------------- reset mid-operation ----------------
        cmd_ready_i = 1'b0;
        btn_n_i = 5'b11000;              // keys 0,1,2 at edge k
        tick(6);                         // after k+5: two queued, key 2 pending
        chk("mid_cnt_before", 8'(fifo_cnt_o), 8'd2);
        rst     = 1'b1;
        btn_n_i = 5'b11111;
        tick(1);
        chk("mid_valid", 8'(cmd_valid_o), 8'd0);
        chk("mid_cnt",   8'(fifo_cnt_o),  8'd0);
        chk("mid_ovf",   8'(overflow_o),  8'd0);
        chk("mid_pressed", 8'(pressed_o), 8'd0);
        rst = 1'b0;
        cmd_ready_i = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (cmd_valid_o) vcnt++;
        end
        chk("mid_no_cmd", 8'(vcnt), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
